// File: rtl/decode_stage.sv
// decode_stage: registered instruction decode with register file, write-back forwarding, load-use stall, flush and sticky halt
// Inputs: fetch side (in_valid, pc, pc_plus1, inst), flush, write-back (wb_en, wb_reg, wb_data), out_ready from execute.
// Outputs: in_ready to fetch, and the ID/EX register (out_valid, pc_out, inst_out, operands, indices, control, alu_ctrl), halted.
module decode_stage #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 16,
  parameter int BYPASS = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] pc,
  input  logic [ADDR_W-1:0] pc_plus1,
  input  logic [15:0]       inst,
  input  logic              flush,
  input  logic              wb_en,
  input  logic [2:0]        wb_reg,
  input  logic [DATA_W-1:0] wb_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] pc_out,
  output logic [15:0]       inst_out,
  output logic [DATA_W-1:0] reg1_data,
  output logic [DATA_W-1:0] reg2_data,
  output logic [2:0]        src1,
  output logic [2:0]        src2,
  output logic [2:0]        wr_reg,
  output logic              wr_en,
  output logic              branch,
  output logic              jump,
  output logic              rqrd_or_imm,
  output logic              rs_or_imm,
  output logic              mem_write,
  output logic              mem_read,
  output logic              pixel_en,
  output logic              pixel_value,
  output logic              read_coord,
  output logic [3:0]        alu_ctrl,
  output logic              halted
);
  logic [DATA_W-1:0] r_rf [8];
  logic              r_valid, r_halted;
  logic [ADDR_W-1:0] r_pc;
  logic [15:0]       r_inst;
  logic [DATA_W-1:0] r_d1, r_d2;
  logic [2:0]        r_s1, r_s2, r_wr;
  logic [9:0]        r_ctrl;
  logic [3:0]        r_alu;
  logic [3:0]        w_op;
  logic [2:0]        w_src1, w_src2;
  logic [9:0]        w_ctrl;
  logic [3:0]        w_alu;
  logic [DATA_W-1:0] w_rd1, w_rd2;
  logic              w_hazard, w_accept;
  assign w_op   = inst[15:12];
  assign w_src1 = inst[14] ? inst[11:9] : inst[5:3];
  assign w_src2 = inst[8:6];
  // control bit order: branch, jump, rqrd_or_imm, rs_or_imm, mem_write, mem_read, pixel_en, pixel_value, read_coord, wr_en
  assign w_ctrl = {w_op == 4'b0010, w_op == 4'b0100, w_op == 4'b0111 || w_op == 4'b1000, w_op[3] & w_op[2],
                   w_op == 4'b0111, w_op == 4'b1000, w_op == 4'b0101, inst[0], w_op == 4'b1001,
                   w_op[3] | (w_op == 4'b0110)};
  always_comb begin
    w_alu = (w_op[3:2] == 2'b11) ? {2'b00, w_op[1:0]} :
            (w_op == 4'b1011)    ? ((inst[2:0] == 3'd0) ? 4'b1000 : {1'b0, inst[2:0]}) :
            (w_op == 4'b1010)    ? {1'b1, inst[2:0]} : 4'b1111;
  end
  assign w_rd1 = (BYPASS != 0 && wb_en && wb_reg == w_src1) ? wb_data : r_rf[w_src1];
  assign w_rd2 = (BYPASS != 0 && wb_en && wb_reg == w_src2) ? wb_data : r_rf[w_src2];
  // conservative: any index match against an in-flight load stalls, whether or not the operand is used
  assign w_hazard = r_valid & r_ctrl[4] & ((r_wr == w_src1) | (r_wr == w_src2));
  // during flush the input is consumed and discarded
  assign in_ready = rst & (flush | (~r_halted & ~w_hazard & (~r_valid | out_ready)));
  assign w_accept = in_valid & in_ready & ~flush;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 8; i++) r_rf[i] <= '0;
    end else if (wb_en) begin
      r_rf[wb_reg] <= wb_data;
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_valid  <= 1'b0;
      r_halted <= 1'b0;
      r_pc     <= '0;
      r_inst   <= '0;
      r_d1     <= '0;
      r_d2     <= '0;
      r_s1     <= '0;
      r_s2     <= '0;
      r_wr     <= '0;
      r_ctrl   <= '0;
      r_alu    <= 4'b1111;
    end else if (flush) begin
      r_valid  <= 1'b0;
      r_halted <= 1'b0;
    end else if (w_accept) begin
      r_valid  <= 1'b1;
      r_halted <= r_halted | (w_op == 4'b0000);
      r_pc     <= (w_op == 4'b0000) ? pc : pc_plus1;
      r_inst   <= inst;
      r_d1     <= w_rd1;
      r_d2     <= w_rd2;
      r_s1     <= w_src1;
      r_s2     <= w_src2;
      r_wr     <= inst[11:9];
      r_ctrl   <= w_ctrl;
      r_alu    <= w_alu;
    end else if (r_valid && out_ready) begin
      r_valid  <= 1'b0;
    end
  end
  assign out_valid = r_valid;
  assign halted    = r_halted;
  assign pc_out    = r_pc;
  assign inst_out  = r_inst;
  assign reg1_data = r_d1;
  assign reg2_data = r_d2;
  assign src1      = r_s1;
  assign src2      = r_s2;
  assign wr_reg    = r_wr;
  assign alu_ctrl  = r_alu;
  assign {branch, jump, rqrd_or_imm, rs_or_imm, mem_write, mem_read, pixel_en, pixel_value, read_coord, wr_en} = r_ctrl;
endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: randomized and directed checks of decode_stage against a spec-level model
module tb_decode_stage;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;
  logic        in_valid, flush, wb_en, out_ready;
  logic [15:0] pc, pc_plus1, inst;
  logic [2:0]  wb_reg;
  logic [31:0] wb_data;
  logic        in_ready, out_valid, wr_en, branch, jump, rqrd_or_imm, rs_or_imm, mem_write, mem_read;
  logic        pixel_en, pixel_value, read_coord, halted;
  logic [15:0] pc_out, inst_out;
  logic [31:0] reg1_data, reg2_data;
  logic [2:0]  src1, src2, wr_reg;
  logic [3:0]  alu_ctrl;
  logic        nb_in_ready, nb_out_valid, nb_wr_en, nb_branch, nb_jump, nb_rqrd, nb_rs, nb_mw, nb_mr;
  logic        nb_pe, nb_pv, nb_rc, nb_halted;
  logic [15:0] nb_pc_out, nb_inst_out;
  logic [31:0] nb_reg1_data, nb_reg2_data;
  logic [2:0]  nb_src1, nb_src2, nb_wr_reg;
  logic [3:0]  nb_alu;
  decode_stage #(.DATA_W(32), .ADDR_W(16), .BYPASS(1)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .pc(pc), .pc_plus1(pc_plus1),
    .inst(inst), .flush(flush), .wb_en(wb_en), .wb_reg(wb_reg), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready), .pc_out(pc_out), .inst_out(inst_out),
    .reg1_data(reg1_data), .reg2_data(reg2_data), .src1(src1), .src2(src2), .wr_reg(wr_reg),
    .wr_en(wr_en), .branch(branch), .jump(jump), .rqrd_or_imm(rqrd_or_imm), .rs_or_imm(rs_or_imm),
    .mem_write(mem_write), .mem_read(mem_read), .pixel_en(pixel_en), .pixel_value(pixel_value),
    .read_coord(read_coord), .alu_ctrl(alu_ctrl), .halted(halted));
  decode_stage #(.DATA_W(32), .ADDR_W(16), .BYPASS(0)) u_nb (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(nb_in_ready), .pc(pc), .pc_plus1(pc_plus1),
    .inst(inst), .flush(flush), .wb_en(wb_en), .wb_reg(wb_reg), .wb_data(wb_data),
    .out_valid(nb_out_valid), .out_ready(out_ready), .pc_out(nb_pc_out), .inst_out(nb_inst_out),
    .reg1_data(nb_reg1_data), .reg2_data(nb_reg2_data), .src1(nb_src1), .src2(nb_src2), .wr_reg(nb_wr_reg),
    .wr_en(nb_wr_en), .branch(nb_branch), .jump(nb_jump), .rqrd_or_imm(nb_rqrd), .rs_or_imm(nb_rs),
    .mem_write(nb_mw), .mem_read(nb_mr), .pixel_en(nb_pe), .pixel_value(nb_pv),
    .read_coord(nb_rc), .alu_ctrl(nb_alu), .halted(nb_halted));
  logic [118:0] w_obs;
  assign w_obs = {pc_out, inst_out, reg1_data, reg2_data, src1, src2, wr_reg, wr_en, branch, jump,
                  rqrd_or_imm, rs_or_imm, mem_write, mem_read, pixel_en, pixel_value, read_coord, alu_ctrl};
  localparam logic [118:0] RST_VEC = {115'd0, 4'hF};
  int total = 0;
  int bad = 0;
  logic [31:0]  rf [8];
  logic         m_valid, m_halted, m_mr, m_ready, m_acc;
  logic [2:0]   m_wrr;
  logic [118:0] m_out, m_next;
  function automatic logic [118:0] mdl(input logic [15:0] i, input logic [15:0] p, input logic [31:0] a, input logic [31:0] b);
    int op;
    int lo;
    logic [3:0] alu;
    op = int'(i[15:12]);
    lo = int'(i[2:0]);
    if (op >= 12) alu = 4'(op - 12);
    else if (op == 11) alu = (lo == 0) ? 4'd8 : 4'(lo);
    else if (op == 10) alu = 4'(8 + lo);
    else alu = 4'd15;
    return {(op == 0) ? p : 16'(p + 16'd1), i, a, b, i[14] ? i[11:9] : i[5:3], i[8:6], i[11:9],
            op >= 8 || op == 6, op == 2, op == 4, op == 7 || op == 8, op >= 12, op == 7, op == 8,
            op == 5, i[0], op == 9, alu};
  endfunction
  function automatic logic [31:0] rd(input logic [2:0] idx);
    return (wb_en && wb_reg == idx) ? wb_data : rf[idx];
  endfunction
  task automatic model_reset();
    m_valid = 1'b0;
    m_halted = 1'b0;
    m_mr = 1'b0;
    m_wrr = 3'd0;
    m_out = RST_VEC;
    for (int i = 0; i < 8; i++) rf[i] = 32'd0;
  endtask
  task automatic drive(input logic iv, input logic [15:0] ins, input logic [15:0] p, input logic fl,
                       input logic orr, input logic wbe, input logic [2:0] wbr, input logic [31:0] wbd);
    logic [2:0] s1, s2;
    in_valid = iv; inst = ins; pc = p; pc_plus1 = p + 16'd1; flush = fl; out_ready = orr;
    wb_en = wbe; wb_reg = wbr; wb_data = wbd;
    #1;
    s1 = ins[14] ? ins[11:9] : ins[5:3];
    s2 = ins[8:6];
    m_ready = fl || (!m_halted && !(m_valid && m_mr && (m_wrr == s1 || m_wrr == s2)) && (!m_valid || orr));
    m_acc = iv && m_ready && !fl;
    m_next = mdl(ins, p, rd(s1), rd(s2));
  endtask
  task automatic tick();
    @(posedge clk);
    if (flush) begin
      m_valid = 1'b0;
      m_halted = 1'b0;
    end else if (m_acc) begin
      m_out = m_next;
      m_mr = inst[15:12] == 4'b1000;
      m_wrr = inst[11:9];
      m_valid = 1'b1;
      if (inst[15:12] == 4'b0000) m_halted = 1'b1;
    end else if (m_valid && out_ready) begin
      m_valid = 1'b0;
    end
    if (wb_en) rf[wb_reg] = wb_data;
    @(negedge clk);
  endtask
  task automatic test_reset();
    model_reset();
    drive(0, 16'h0, 16'h0, 0, 1, 0, 3'd0, 32'd0);
    repeat (2) @(negedge clk);
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_ready got=%0b exp=0", in_ready); end
    total++; if (out_valid !== 1'b0 || halted !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0b/%0b exp=0/0", out_valid, halted); end
    total++; if (w_obs !== RST_VEC) begin bad++; $display("FAIL reset_outputs got=%h exp=%h", w_obs, RST_VEC); end
    rst = 1'b1;
    drive(0, 16'h0, 16'h0, 0, 1, 0, 3'd0, 32'd0);
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_release_ready got=%0b exp=1", in_ready); end
  endtask
  task automatic test_add();
    drive(1, 16'hC640, 16'h0010, 0, 1, 0, 3'd0, 32'd0);
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL add_ready got=%0b exp=1", in_ready); end
    tick();
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL add_valid got=%0b exp=1", out_valid); end
    total++; if (alu_ctrl !== 4'b0000 || rs_or_imm !== 1'b1 || wr_en !== 1'b1 || wr_reg !== 3'd3)
      begin bad++; $display("FAIL add_ctrl got alu=%b rs=%0b we=%0b wr=%0d exp alu=0000 rs=1 we=1 wr=3", alu_ctrl, rs_or_imm, wr_en, wr_reg); end
    total++; if (pc_out !== 16'h0011) begin bad++; $display("FAIL add_pc got=%h exp=0011", pc_out); end
    total++; if (w_obs !== m_out) begin bad++; $display("FAIL add_fields got=%h exp=%h", w_obs, m_out); end
    drive(1, 16'hC640, 16'h0011, 0, 1, 0, 3'd0, 32'd0);
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready got=%0b exp=1", in_ready); end
    tick();
    total++; if (out_valid !== 1'b1 || pc_out !== 16'h0012) begin bad++; $display("FAIL b2b_out got=%0b/%h exp=1/0012", out_valid, pc_out); end
  endtask
  task automatic test_load_use();
    drive(1, 16'h8400, 16'h0020, 0, 1, 0, 3'd0, 32'd0);
    tick();
    total++; if (mem_read !== 1'b1 || wr_reg !== 3'd2) begin bad++; $display("FAIL load_out got mr=%0b wr=%0d exp mr=1 wr=2", mem_read, wr_reg); end
    drive(1, 16'hC440, 16'h0021, 0, 1, 0, 3'd0, 32'd0);
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL hazard_ready got=%0b exp=0", in_ready); end
    tick();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL hazard_bubble got=%0b exp=0", out_valid); end
    drive(1, 16'hC440, 16'h0021, 0, 1, 0, 3'd0, 32'd0);
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL hazard_release got=%0b exp=1", in_ready); end
    tick();
    total++; if (out_valid !== 1'b1 || inst_out !== 16'hC440) begin bad++; $display("FAIL hazard_accept got=%0b/%h exp=1/c440", out_valid, inst_out); end
    drive(1, 16'h8400, 16'h0022, 0, 1, 0, 3'd0, 32'd0);
    tick();
    drive(1, 16'hC640, 16'h0023, 0, 1, 0, 3'd0, 32'd0);
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL indep_ready got=%0b exp=1", in_ready); end
    tick();
    total++; if (out_valid !== 1'b1 || w_obs !== m_out) begin bad++; $display("FAIL indep_out got=%h exp=%h", w_obs, m_out); end
  endtask
  task automatic test_bypass();
    drive(1, 16'hCA00, 16'h0030, 0, 1, 1, 3'd5, 32'hDEADBEEF);
    tick();
    total++; if (reg1_data !== 32'hDEADBEEF) begin bad++; $display("FAIL bypass_on got=%h exp=deadbeef", reg1_data); end
    total++; if (nb_reg1_data !== 32'h0) begin bad++; $display("FAIL bypass_off got=%h exp=00000000", nb_reg1_data); end
    drive(1, 16'hCA00, 16'h0031, 0, 1, 0, 3'd0, 32'd0);
    tick();
    total++; if (reg1_data !== 32'hDEADBEEF || nb_reg1_data !== 32'hDEADBEEF)
      begin bad++; $display("FAIL wb_next got=%h/%h exp=deadbeef/deadbeef", reg1_data, nb_reg1_data); end
  endtask
  task automatic test_halt_flush();
    drive(1, 16'h0000, 16'h0040, 0, 1, 0, 3'd0, 32'd0);
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL halt_ready got=%0b exp=1", in_ready); end
    tick();
    total++; if (pc_out !== 16'h0040 || halted !== 1'b1 || out_valid !== 1'b1)
      begin bad++; $display("FAIL halt_out got pc=%h h=%0b v=%0b exp pc=0040 h=1 v=1", pc_out, halted, out_valid); end
    for (int i = 0; i < 20; i++) begin
      drive(1, 16'hC640, 16'h0041, 0, 1, 0, 3'd0, 32'd0);
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL halt_hold cyc=%0d got=%0b exp=0", i, in_ready); end
      tick();
    end
    drive(1, 16'hC640, 16'h0041, 1, 1, 0, 3'd0, 32'd0);
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL flush_ready got=%0b exp=1", in_ready); end
    tick();
    total++; if (halted !== 1'b0 || out_valid !== 1'b0) begin bad++; $display("FAIL flush_state got h=%0b v=%0b exp 0/0", halted, out_valid); end
    drive(1, 16'hC640, 16'h0050, 0, 1, 0, 3'd0, 32'd0);
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL post_flush_ready got=%0b exp=1", in_ready); end
    tick();
  endtask
  task automatic test_stall();
    logic [118:0] snap;
    drive(1, 16'hB205, 16'h0060, 0, 1, 0, 3'd0, 32'd0);
    tick();
    snap = w_obs;
    total++; if (w_obs !== m_out || alu_ctrl !== 4'b0101) begin bad++; $display("FAIL stall_load got=%h exp=%h", w_obs, m_out); end
    for (int i = 0; i < 3; i++) begin
      drive(1, 16'hA203, 16'h0061, 0, 0, 0, 3'd0, 32'd0);
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL stall_ready cyc=%0d got=%0b exp=0", i, in_ready); end
      tick();
      total++; if (out_valid !== 1'b1 || w_obs !== snap) begin bad++; $display("FAIL stall_hold cyc=%0d got=%h exp=%h", i, w_obs, snap); end
    end
    drive(1, 16'hA203, 16'h0061, 0, 1, 0, 3'd0, 32'd0);
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL stall_release got=%0b exp=1", in_ready); end
    tick();
    total++; if (inst_out !== 16'hA203 || alu_ctrl !== 4'b1011) begin bad++; $display("FAIL stall_next got=%h/%b exp=a203/1011", inst_out, alu_ctrl); end
  endtask
  task automatic test_reset_mid();
    drive(1, 16'h8400, 16'h0070, 0, 1, 0, 3'd0, 32'd0);
    tick();
    drive(1, 16'hC440, 16'h0071, 0, 1, 0, 3'd0, 32'd0);
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL midrst_hazard got=%0b exp=0", in_ready); end
    rst = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0 || in_ready !== 1'b0 || w_obs !== RST_VEC)
      begin bad++; $display("FAIL midrst_async got v=%0b r=%0b o=%h exp 0/0/%h", out_valid, in_ready, w_obs, RST_VEC); end
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    drive(1, 16'hCA00, 16'h0072, 0, 1, 0, 3'd0, 32'd0);
    tick();
    total++; if (reg1_data !== 32'h0 || w_obs !== m_out) begin bad++; $display("FAIL midrst_rf got=%h exp=%h", w_obs, m_out); end
  endtask
  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      drive($urandom_range(0, 9) < 7, 16'($urandom), 16'($urandom), $urandom_range(0, 19) == 0,
            $urandom_range(0, 9) < 7, 1'($urandom), 3'($urandom), $urandom);
      total++; if (in_ready !== m_ready) begin bad++; $display("FAIL rand_ready cyc=%0d got=%0b exp=%0b", i, in_ready, m_ready); end
      tick();
      total++; if (out_valid !== m_valid || halted !== m_halted)
        begin bad++; $display("FAIL rand_state cyc=%0d got v=%0b h=%0b exp v=%0b h=%0b", i, out_valid, halted, m_valid, m_halted); end
      if (m_valid) begin
        total++; if (w_obs !== m_out) begin bad++; $display("FAIL rand_out cyc=%0d got=%h exp=%h", i, w_obs, m_out); end
      end
    end
  endtask
  initial begin
    test_reset();
    test_add();
    test_load_use();
    test_bypass();
    test_halt_flush();
    test_stall();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/decode_stage.md
# decode_stage

Parametrised, registered instruction-decode stage for the CPU pipeline. It sits between fetch and execute and owns the architectural register file, with write-back forwarding. It decodes the 16-bit instruction into control signals and reads both source operands. Results are registered into an ID/EX output register behind a valid/ready handshake. It also detects load-use hazards (inserting bubbles), supports pipeline flush, and latches a sticky halt.

## Interface
Parameters:
- DATA_W, 32, register/operand width
- ADDR_W, 16, PC width
- BYPASS, 1, 1 = same-cycle write-back forwarded to operand reads; 0 = read old value

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- in_valid  in  1  fetch offers an instruction
- in_ready  out  1  stage accepts this cycle
- pc, pc_plus1  in  ADDR_W  PC of instruction / PC+1
- inst  in  16  instruction word
- flush  in  1  kill ID/EX contents and the current input
- wb_en  in  1  register write enable
- wb_reg  in  3  write index
- wb_data  in  DATA_W  write data
- out_valid  out  1  ID/EX register holds a live instruction
- out_ready  in  1  execute accepts
- pc_out  out  ADDR_W  registered next PC (pc for halt, else pc_plus1)
- inst_out  out  16  registered instruction
- reg1_data, reg2_data  out  DATA_W  registered operands
- src1, src2  out  3  registered source indices
- wr_reg  out  3; wr_en  out  1
- branch, jump, rqrd_or_imm, rs_or_imm, mem_write, mem_read, pixel_en, pixel_value, read_coord  out  1 each
- alu_ctrl  out  4
- halted  out  1  sticky halt status

## Operation
- op = inst[15:12]. Decoded fields:
  - src1 = inst[14] ? inst[11:9] : inst[5:3]; src2 = inst[8:6]; wr_reg = inst[11:9].
  - branch = op==0010; jump = op==0100; pixel_en = op==0101; mem_write = op==0111; mem_read = op==1000; read_coord = op==1001.
  - rqrd_or_imm = op∈{0111,1000}; rs_or_imm = op[3]&op[2]; wr_en = op[3] | op==0110; pixel_value = inst[0].
- alu_ctrl:
  - 1100→0000, 1101→0001, 1110→0010, 1111→0011.
  - 1011→{0,inst[2:0]}, or 1000 if inst[2:0]==0.
  - 1010→{1,inst[2:0]}; all others→1111.
- Register file: 8 × DATA_W.
  - Write on wb_en at clock edge.
  - With BYPASS=1, a read index equal to wb_reg while wb_en is high returns wb_data.
- Hazard (combinational): out_valid & mem_read(out) & (wr_reg(out)==src1 | wr_reg(out)==src2). The check is conservative and ignores operand use.
- in_ready = rst & ~halted & ~hazard & (~out_valid | out_ready).
- Accept = in_valid & in_ready. On accept the ID/EX register loads all decoded fields and operands, and out_valid←1.
- If out_valid & out_ready without accept: out_valid←0. A hazard therefore yields exactly one bubble, then the instruction is accepted.
- Halt (op==0000): on accept, halted←1 and in_ready stays 0 until reset or flush. The halt instruction itself is forwarded with pc_out=pc.
- Flush (priority over everything except reset):
  - Next edge: out_valid←0 and halted←0. The ID/EX register does not load.
  - in_ready is forced 1 during flush, so a valid input is consumed and dropped.
  - The register file still performs wb writes.

## Timing
- Reset (async, rst=0):
  - out_valid, halted, all control outputs, alu_ctrl=1111 and data outputs = 0.
  - All registers = 0.
  - in_ready=0 while rst low.
- Latency: one cycle, input accept to out_valid.
- Throughput: one instruction per cycle when out_ready is held high and no hazard occurs.
- Outputs are stable while out_valid & ~out_ready (hold).
- Write-back in cycle N is visible to a read in cycle N:
  - via bypass when BYPASS=1;
  - otherwise from N+1.
- Simultaneous wb write and read of a different index: no interaction.
- Reset asserted mid-stall or mid-halt: immediate return to reset state.

## Test plan
- Reset, then stream ADD imm (op 1100, wr_reg 3) with out_ready=1 → out_valid one cycle after accept, alu_ctrl=0000, rs_or_imm=1, wr_en=1, pc_out=pc_plus1.
- Load r2 (op 1000) followed by instruction with src1=2 → exactly one cycle in_ready=0 with out_valid=0 bubble, then accepted; an independent follower (src≠2) incurs no bubble.
- wb_en=1, wb_reg=5, wb_data=0xDEADBEEF in the same cycle an instruction reads r5 → reg1_data=0xDEADBEEF with BYPASS=1; old value (0) with BYPASS=0.
- Halt at pc=0x0040 → pc_out=0x0040, halted=1, in_ready stays 0 for 20 cycles. Then flush → halted=0 and in_ready=1 next cycle.
- out_ready=0 for 3 cycles with out_valid=1 → all outputs held constant and in_ready=0. out_ready=1 → next instruction accepted.
- Drop rst while out_valid=1 and mid-hazard → outputs zero asynchronously and registers read 0 after release.
